// File: rtl/test_demux_reg.sv
// Registered 1-to-2 demultiplexer: a D/S handshake steers each word into one of
// two holding registers, each drained by its own valid/ready handshake.
module test_demux_reg #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             D_valid,
  output logic             D_ready,
  output logic [WIDTH-1:0] Q0,
  output logic             Q0_valid,
  input  logic             Q0_ready,
  output logic [WIDTH-1:0] Q1,
  output logic             Q1_valid,
  input  logic             Q1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             err
);

  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;
  logic             r_q0_valid;
  logic             r_q1_valid;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             r_err;

  logic w_dready;
  logic w_acc;
  logic w_ld0;
  logic w_ld1;
  logic w_ill;
  logic w_dr0;
  logic w_dr1;

  // Input acceptance: a slot is free if empty or draining this cycle; illegal selects always consumed.
  always_comb begin
    w_dready = 1'b0;
    if (!rst_n) begin
      w_dready = 1'b0;
    end else begin
      case (S)
        2'd0:    w_dready = !r_q0_valid | Q0_ready;
        2'd1:    w_dready = !r_q1_valid | Q1_ready;
        default: w_dready = 1'b1;
      endcase
    end
  end

  // Gating every strobe with w_acc keeps an X on S harmless while D_valid is low.
  assign w_acc = D_valid & w_dready;
  assign w_ld0 = w_acc & (S == 2'd0);
  assign w_ld1 = w_acc & (S == 2'd1);
  assign w_ill = w_acc & S[1];
  assign w_dr0 = r_q0_valid & Q0_ready;
  assign w_dr1 = r_q1_valid & Q1_ready;

  // Channel 0 holding register: load wins over drain so a simultaneous pair stays FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q0       <= '0;
      r_q0_valid <= 1'b0;
    end else if (w_ld0) begin
      r_q0       <= D;
      r_q0_valid <= 1'b1;
    end else if (w_dr0) begin
      r_q0_valid <= 1'b0;
    end else begin
      r_q0_valid <= r_q0_valid;
    end
  end

  // Channel 1 holding register, mirror of channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1       <= '0;
      r_q1_valid <= 1'b0;
    end else if (w_ld1) begin
      r_q1       <= D;
      r_q1_valid <= 1'b1;
    end else if (w_dr1) begin
      r_q1_valid <= 1'b0;
    end else begin
      r_q1_valid <= r_q1_valid;
    end
  end

  // Delivery counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_dr0) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end else begin
        r_cnt0 <= r_cnt0;
      end
      if (w_dr1) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end else begin
        r_cnt1 <= r_cnt1;
      end
    end
  end

  // Sticky illegal-select flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_ill) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign D_ready  = w_dready;
  assign Q0       = r_q0;
  assign Q0_valid = r_q0_valid;
  assign Q1       = r_q1;
  assign Q1_valid = r_q1_valid;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;
  assign err      = r_err;

endmodule

// File: tb/tb_test_demux_reg.sv
// Directed self-checking bench for test_demux_reg: routing, backpressure,
// streaming, illegal select, counter wrap and asynchronous reset.
module tb_test_demux_reg;

  localparam int WIDTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [1:0]       S;
  logic [WIDTH-1:0] D;
  logic             D_valid;
  logic             D_ready;
  logic [WIDTH-1:0] Q0;
  logic             Q0_valid;
  logic             Q0_ready;
  logic [WIDTH-1:0] Q1;
  logic             Q1_valid;
  logic             Q1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             err;

  int checks;
  int errors;

  test_demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .S(S), .D(D), .D_valid(D_valid), .D_ready(D_ready),
    .Q0(Q0), .Q0_valid(Q0_valid), .Q0_ready(Q0_ready),
    .Q1(Q1), .Q1_valid(Q1_valid), .Q1_ready(Q1_ready),
    .cnt0(cnt0), .cnt1(cnt1), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    S        = 2'd0;
    D        = 2'd0;
    D_valid  = 1'b0;
    Q0_ready = 1'b0;
    Q1_ready = 1'b0;

    // Reset held across clocks
    repeat (3) tick();
    chk("rst_q0", {30'd0, Q0}, 32'd0);
    chk("rst_q1", {30'd0, Q1}, 32'd0);
    chk("rst_v0", {31'd0, Q0_valid}, 32'd0);
    chk("rst_v1", {31'd0, Q1_valid}, 32'd0);
    chk("rst_cnt0", {24'd0, cnt0}, 32'd0);
    chk("rst_cnt1", {24'd0, cnt1}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dready", {31'd0, D_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_dready", {31'd0, D_ready}, 32'd1);

    // Basic routing
    D = 2'b01; S = 2'd0; D_valid = 1'b1;
    tick();
    chk("route_q0", {30'd0, Q0}, 32'd1);
    chk("route_v0", {31'd0, Q0_valid}, 32'd1);
    D = 2'b10; S = 2'd1;
    tick();
    D_valid = 1'b0;
    chk("route_q1", {30'd0, Q1}, 32'd2);
    chk("route_v1", {31'd0, Q1_valid}, 32'd1);
    chk("route_q0_hold", {30'd0, Q0}, 32'd1);
    Q0_ready = 1'b1; Q1_ready = 1'b1;
    tick();
    Q0_ready = 1'b0; Q1_ready = 1'b0;
    chk("drain_v0", {31'd0, Q0_valid}, 32'd0);
    chk("drain_v1", {31'd0, Q1_valid}, 32'd0);
    chk("drain_cnt0", {24'd0, cnt0}, 32'd1);
    chk("drain_cnt1", {24'd0, cnt1}, 32'd1);

    // Backpressure on channel 0 does not block channel 1
    D = 2'b11; S = 2'd0; D_valid = 1'b1;
    tick();
    D = 2'b00;
    #1;
    chk("bp_dready0", {31'd0, D_ready}, 32'd0);
    tick();
    chk("bp_q0_hold", {30'd0, Q0}, 32'd3);
    chk("bp_v0_hold", {31'd0, Q0_valid}, 32'd1);
    S = 2'd1; D = 2'b01;
    #1;
    chk("bp_dready1", {31'd0, D_ready}, 32'd1);
    tick();
    D_valid = 1'b0;
    chk("bp_q1", {30'd0, Q1}, 32'd1);
    chk("bp_q0_still", {30'd0, Q0}, 32'd3);
    Q0_ready = 1'b1; Q1_ready = 1'b1;
    tick();
    Q1_ready = 1'b0;
    chk("bp_cnt0", {24'd0, cnt0}, 32'd2);
    chk("bp_cnt1", {24'd0, cnt1}, 32'd2);

    // Ready on an empty channel has no effect
    tick();
    chk("empty_ready_cnt0", {24'd0, cnt0}, 32'd2);
    chk("empty_ready_v0", {31'd0, Q0_valid}, 32'd0);

    // Streaming on channel 0 with no bubbles
    S = 2'd0; D_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      D = i[1:0];
      #1;
      chk("stream_dready", {31'd0, D_ready}, 32'd1);
      tick();
      chk("stream_q0", {30'd0, Q0}, i);
      chk("stream_v0", {31'd0, Q0_valid}, 32'd1);
    end
    D_valid = 1'b0;
    tick();
    Q0_ready = 1'b0;
    chk("stream_v0_end", {31'd0, Q0_valid}, 32'd0);
    chk("stream_cnt0", {24'd0, cnt0}, 32'd6);

    // Illegal select drops the word and sets the sticky flag
    S = 2'd2; D = 2'b11; D_valid = 1'b1;
    #1;
    chk("ill_dready", {31'd0, D_ready}, 32'd1);
    tick();
    D_valid = 1'b0;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_v0", {31'd0, Q0_valid}, 32'd0);
    chk("ill_v1", {31'd0, Q1_valid}, 32'd0);
    S = 2'bxx;
    repeat (10) tick();
    chk("ill_err_sticky", {31'd0, err}, 32'd1);
    chk("x_sel_v0", {31'd0, Q0_valid}, 32'd0);
    chk("x_sel_v1", {31'd0, Q1_valid}, 32'd0);
    chk("x_sel_cnt0", {24'd0, cnt0}, 32'd6);

    // Counter wrap on channel 1: 254 more drains take 2 -> 0
    S = 2'd1; D_valid = 1'b1; Q1_ready = 1'b1;
    for (int i = 0; i < 254; i++) begin
      D = i[1:0];
      tick();
    end
    chk("wrap_q1", {30'd0, Q1}, 32'd1);
    D_valid = 1'b0;
    chk("wrap_cnt1_255", {24'd0, cnt1}, 32'd255);
    tick();
    Q1_ready = 1'b0;
    chk("wrap_cnt1_0", {24'd0, cnt1}, 32'd0);
    chk("wrap_v1", {31'd0, Q1_valid}, 32'd0);

    // Async reset between edges with both channels full
    S = 2'd0; D = 2'b01; D_valid = 1'b1;
    tick();
    S = 2'd1; D = 2'b10;
    tick();
    D_valid = 1'b0;
    chk("pre_rst_v0", {31'd0, Q0_valid}, 32'd1);
    chk("pre_rst_v1", {31'd0, Q1_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_v0", {31'd0, Q0_valid}, 32'd0);
    chk("arst_v1", {31'd0, Q1_valid}, 32'd0);
    chk("arst_q0", {30'd0, Q0}, 32'd0);
    chk("arst_q1", {30'd0, Q1}, 32'd0);
    chk("arst_cnt0", {24'd0, cnt0}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_dready", {31'd0, D_ready}, 32'd0);

    // Recovery after reset
    @(negedge clk);
    rst_n = 1'b1;
    S = 2'd0; D = 2'b10; D_valid = 1'b1;
    tick();
    D_valid = 1'b0;
    chk("post_q0", {30'd0, Q0}, 32'd2);
    chk("post_v0", {31'd0, Q0_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
